mac_sequencer: RTL
==================

// Module: mac_sequencer
// PURPOSE
//  Sequences one mac instance through one dot-product job (a single neuron output).
//  Fetches activation/weight pairs from two sync-read buffers, clears the MAC, streams N products,
//  flushes the MAC's one-beat output lag, then captures the quantized result.
//  Sits between layer control (start/len) and the neuron datapath (mac + buffers).
// PARAMETERS
//  WIDTH    8    operand/result width; must match the mac WIDTH
//  MAX_LEN  16   max vector length; the mac ACCUMULATIONS must be >= MAX_LEN+1
//  ADDR_W   $clog2(MAX_LEN)    buffer address width (derived)
//  LEN_W    $clog2(MAX_LEN+1)  length field width (derived)
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high
//  start         in   1       job request; accepted only in IDLE
//  len           in   LEN_W   vector length, sampled when start is accepted
//  busy          out  1       state != IDLE
//  rd_en         out  1       read strobe to both buffers; data returns next cycle
//  rd_addr       out  ADDR_W  shared activation/weight address
//  act_data      in   WIDTH   activation buffer read data
//  wt_data       in   WIDTH   weight buffer read data
//  mac_clear     out  1       drives the mac reset; registered, glitch-free
//  mac_enable    out  1       mac enable
//  mac_a, mac_b  out  WIDTH   mac operands (combinational mux)
//  mac_out       in   WIDTH   mac quantized output
//  result        out  WIDTH   captured neuron result, held while result_valid
//  result_valid  out  1       result available
//  result_ready  in   1       consumer accepts result
// BEHAVIOUR
//  Reset: state=IDLE; busy, rd_en, mac_clear, mac_enable, result_valid = 0; rd_addr, result, counters = 0.
//  Reset mid-job aborts immediately to IDLE; the next job's CLEAR state sanitises the mac.
//  States:
//   IDLE
//    start=1 -> CLEAR; latch len_q = min(len, MAX_LEN).
//   CLEAR (1 cycle)
//    mac_clear=1.
//    If len_q>0: rd_en=1, rd_addr=0, then -> RUN. Otherwise -> FLUSH.
//   RUN (len_q cycles, beat j = 0..len_q-1)
//    mac_enable=1; mac_a=act_data; mac_b=wt_data.
//    rd_en=1 and rd_addr=j+1 while j+1 < len_q.
//    After the last beat -> BIAS if MAC_SEQ_BIAS_EN, else -> FLUSH.
//   FLUSH (1 cycle)
//    mac_enable=1; mac_a=mac_b=0.
//    The sum is unchanged; mac out <= quantize(total).
//   CAPTURE (1 cycle)
//    result <= mac_out -> DONE.
//   DONE
//    result_valid=1. result_ready=1 -> IDLE (same edge clears result_valid).
//  Latency: start accepted in cycle 0 -> result_valid first high in cycle len_q+4 (+1 with bias).
//  Outside RUN/FLUSH/BIAS: mac_enable=0 and mac_a=mac_b=0.
//  Outside CLEAR/RUN: rd_en=0 and rd_addr holds.
//  start while busy is ignored (no queuing).
//  len=0 -> result = quantize(0).
//  len > MAX_LEN -> clamped to MAX_LEN.
//  result_ready while not DONE has no effect.
// CONFIGURATION
//  MAC_SEQ_BIAS_EN defined:
//   Adds input port bias[WIDTH-1:0], sampled together with len.
//   Adds a BIAS state (1 cycle) between RUN and FLUSH: mac_enable=1, mac_a=bias_q, mac_b=1.
//   The mac ACCUMULATIONS must then be >= MAX_LEN+2.
//  MAC_SEQ_BIAS_EN undefined:
//   No bias port and no BIAS state; RUN -> FLUSH directly.
// STRUCTURE
//  Shared package mac_pkg holds:
//   state encodings (IDLE..DONE, BIAS) as localparams;
//   the WIDTH default;
//   the ACCUMULATIONS sizing rule.
//  No sub-module: beat counter and FSM are inline.
//  Integration wrapper neuron_unit instantiates mac_sequencer + mac.
// TESTING  (golden quantize model from mac_pkg; bench instantiates the real mac)
//  1. len=3, act={1,2,3}, wt={4,5,6}
//     -> mac sees sum 32; result=q(32); result_valid in cycle 7; exactly 4 mac_enable cycles.
//  2. len=0
//     -> no rd_en; one FLUSH enable; result=q(0)=0; result_valid in cycle 4.
//  3. len=16, all operands 255
//     -> sum 1040400; result=q(1040400); rd_addr sequence 0..15; no address beyond 15.
//  4. result_ready held low 5 cycles in DONE, start pulsed meanwhile
//     -> result stable; start ignored; busy stays 1.
//  5. reset asserted in RUN beat 2 of len=8
//     -> outputs immediately at reset values.
//     Next job len=2, act={3,3}, wt={2,2} -> result=q(12) (no stale sum).
//  6. MAC_SEQ_BIAS_EN, bias=7, len=2, act={1,1}, wt={5,5}
//     -> result=q(17); result_valid in cycle 7.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the neuron datapath: sequencer state encodings, mac width
// default, mac accumulation sizing rule and the golden quantize model.
package mac_pkg;

    localparam int MAC_WIDTH = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_BIAS    = 3'd6;

    // The mac must absorb every RUN beat plus the flush beat (and the bias beat when enabled).
    function automatic int macAccumulations(input int maxLen);
`ifdef MAC_SEQ_BIAS_EN
        return maxLen + 2;
`else
        return maxLen + 1;
`endif
    endfunction

    // Saturating quantizer: totals above the result range clip to all-ones.
    function automatic logic [MAC_WIDTH-1:0] quantize(input logic [31:0] total);
        if (total > 32'((1 << MAC_WIDTH) - 1))
            return '1;
        return total[MAC_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mac_sequencer.sv
// Drives one mac through a single dot-product job: clear, stream len products, flush, capture.
// Define MAC_SEQ_BIAS_EN to add a bias port and a BIAS beat between RUN and FLUSH.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int WIDTH   = MAC_WIDTH,
    parameter int MAX_LEN = 16,
    parameter int ADDR_W  = $clog2(MAX_LEN),
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
`ifdef MAC_SEQ_BIAS_EN
    input  logic [WIDTH-1:0]  bias,
`endif
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  act_data,
    input  logic [WIDTH-1:0]  wt_data,
    output logic              mac_clear,
    output logic              mac_enable,
    output logic [WIDTH-1:0]  mac_a,
    output logic [WIDTH-1:0]  mac_b,
    input  logic [WIDTH-1:0]  mac_out,
    output logic [WIDTH-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready
);

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              mac_clear_q;
    logic [LEN_W-1:0]  beatNext;
    logic [LEN_W-1:0]  lenClamped;
`ifdef MAC_SEQ_BIAS_EN
    logic [WIDTH-1:0]  bias_q, bias_d;
`endif

    assign beatNext   = beat_q + 1'b1;
    assign lenClamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        beat_d   = beat_q;
        result_d = result_q;
`ifdef MAC_SEQ_BIAS_EN
        bias_d   = bias_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    len_d   = lenClamped;
                    beat_d  = '0;
`ifdef MAC_SEQ_BIAS_EN
                    bias_d  = bias;
`endif
                end
            end
            ST_CLEAR: begin
                beat_d  = '0;
                state_d = (len_q != '0) ? ST_RUN : ST_FLUSH;
            end
            ST_RUN: begin
                if (beatNext == len_q) begin
`ifdef MAC_SEQ_BIAS_EN
                    state_d = ST_BIAS;
`else
                    state_d = ST_FLUSH;
`endif
                end else begin
                    beat_d = beatNext;
                end
            end
`ifdef MAC_SEQ_BIAS_EN
            ST_BIAS:    state_d = ST_FLUSH;
`endif
            ST_FLUSH:   state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                result_d = mac_out;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (result_ready)
                    state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Reads run one beat ahead of the mac; the address holds its last value once reads stop.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = addr_q;
        if (state_q == ST_CLEAR && len_q != '0) begin
            rd_en   = 1'b1;
            rd_addr = '0;
        end else if (state_q == ST_RUN && beatNext < len_q) begin
            rd_en   = 1'b1;
            rd_addr = ADDR_W'(beatNext);
        end
    end

    always_comb begin
        mac_enable = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        case (state_q)
            ST_RUN: begin
                mac_enable = 1'b1;
                mac_a      = act_data;
                mac_b      = wt_data;
            end
`ifdef MAC_SEQ_BIAS_EN
            ST_BIAS: begin
                mac_enable = 1'b1;
                mac_a      = bias_q;
                mac_b      = WIDTH'(1);
            end
`endif
            ST_FLUSH:  mac_enable = 1'b1;
            default:   mac_enable = 1'b0;
        endcase
    end

    // mac_clear comes straight from a flop so the mac reset input never sees a glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            result_q    <= '0;
            mac_clear_q <= 1'b0;
`ifdef MAC_SEQ_BIAS_EN
            bias_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            addr_q      <= rd_addr;
            result_q    <= result_d;
            mac_clear_q <= (state_d == ST_CLEAR);
`ifdef MAC_SEQ_BIAS_EN
            bias_q      <= bias_d;
`endif
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = result_q;
    assign mac_clear    = mac_clear_q;

endmodule
